// File: rtl/mips_mem_arbiter_pkg.sv
// mips_mem_arbiter_pkg: FSM state and arbitration-mode encodings shared by the memory arbiter
package mips_mem_arbiter_pkg;
  typedef enum logic [1:0] {
    S_ARB    = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_t;
  localparam int ARB_MODE_RR   = 0;
  localparam int ARB_MODE_PRIO = 1;
endpackage

// File: rtl/mips_mem_arbiter_arb_pick2.sv
// arb_pick2: two-requester winner selection (round-robin or p0-priority with starvation override)
//  req0, req1   in   requests from port 0 / port 1
//  last_winner  in   port granted most recently (round-robin history)
//  mode         in   0 = round-robin, 1 = fixed p0 priority
//  starve_hit   in   p1 has waited through the maximum run of p0 grants
//  winner       out  selected port index (meaningful only when any=1)
//  any          out  at least one request present
module arb_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_winner,
  input  logic mode,
  input  logic starve_hit,
  output logic winner,
  output logic any
);
  assign any    = req0 | req1;
  assign winner = (req0 && req1) ? (mode ? starve_hit : !last_winner) : req1;
endmodule

// File: rtl/mips_mem_arbiter.sv
// mips_mem_arbiter: shares the single unified memory port of the multicycle MIPS core between CPU (p0) and DMA (p1)
//  clk, rst           clock; synchronous active-low reset
//  pN_req/we/addr/wdata  request, write flag, byte address, write data of port N
//  pN_gnt             one-cycle accept pulse (combinational, in the arbitration cycle)
//  pN_rvalid/rdata    one-cycle read response and its data
//  mem_addr/mem_wr_data/mem_wr_ena/mem_rd_data  memory-side port
//  busy               transaction in progress
//  owner              port of the current or last transaction
module mips_mem_arbiter
  import mips_mem_arbiter_pkg::*;
#(
  parameter int N             = 32,
  parameter int RD_LATENCY    = 1,
  parameter int PRIORITY_MODE = ARB_MODE_RR,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         p0_req,
  input  logic         p0_we,
  input  logic [N-1:0] p0_addr,
  input  logic [N-1:0] p0_wdata,
  output logic         p0_gnt,
  output logic         p0_rvalid,
  output logic [N-1:0] p0_rdata,
  input  logic         p1_req,
  input  logic         p1_we,
  input  logic [N-1:0] p1_addr,
  input  logic [N-1:0] p1_wdata,
  output logic         p1_gnt,
  output logic         p1_rvalid,
  output logic [N-1:0] p1_rdata,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wr_data,
  output logic         mem_wr_ena,
  input  logic [N-1:0] mem_rd_data,
  output logic         busy,
  output logic         owner
);
  localparam int WW = $clog2(RD_LATENCY + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  state_t state, state_n;
  logic [WW-1:0] wait_cnt;
  logic [SW-1:0] starve_cnt;
  logic [N-1:0] hold_addr, hold_wdata;
  logic hold_we, last_winner, winner, any, grant, resp;
  arb_pick2 u_pick (
    .req0       (p0_req),
    .req1       (p1_req),
    .last_winner(last_winner),
    .mode       (PRIORITY_MODE == ARB_MODE_PRIO),
    .starve_hit (starve_cnt == SW'(STARVE_LIMIT)),
    .winner     (winner),
    .any        (any)
  );
  // Pulses are gated by rst so nothing is accepted, issued or returned while reset is asserted.
  assign grant       = rst && state == S_ARB && any;
  assign resp        = rst && state == S_RESP;
  assign p0_gnt      = grant && !winner;
  assign p1_gnt      = grant && winner;
  assign p0_rvalid   = resp && !owner;
  assign p1_rvalid   = resp && owner;
  assign p0_rdata    = p0_rvalid ? mem_rd_data : '0;
  assign p1_rdata    = p1_rvalid ? mem_rd_data : '0;
  // The holding registers drive the memory directly, so the address is present from the access cycle onward.
  assign mem_addr    = hold_addr;
  assign mem_wr_data = hold_wdata;
  assign mem_wr_ena  = rst && state == S_ACCESS && hold_we;
  assign busy        = state != S_ARB;
  always_comb begin
    state_n = state;
    unique case (state)
      S_ARB:    state_n = any ? S_ACCESS : S_ARB;
      S_ACCESS: state_n = hold_we ? S_ARB : (RD_LATENCY == 1 ? S_RESP : S_WAIT);
      S_WAIT:   state_n = wait_cnt == WW'(1) ? S_RESP : S_WAIT;
      S_RESP:   state_n = S_ARB;
      default:  state_n = S_ARB;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_ARB;
      hold_addr   <= '0;
      hold_wdata  <= '0;
      hold_we     <= 1'b0;
      owner       <= 1'b0;
      last_winner <= 1'b1;
      starve_cnt  <= '0;
      wait_cnt    <= '0;
    end else begin
      state <= state_n;
      if (grant) begin
        hold_addr   <= winner ? p1_addr : p0_addr;
        hold_wdata  <= winner ? p1_wdata : p0_wdata;
        hold_we     <= winner ? p1_we : p0_we;
        owner       <= winner;
        last_winner <= winner;
      end
      // With p1 requesting, every S_ARB cycle is a grant: p0 wins extend the run, a p1 win or idle p1 clears it.
      if (state == S_ARB)
        starve_cnt <= (PRIORITY_MODE == ARB_MODE_PRIO && p1_req && !winner) ? starve_cnt + SW'(1) : '0;
      if (state == S_ACCESS)
        wait_cnt <= WW'(RD_LATENCY - 1);
      else if (state == S_WAIT)
        wait_cnt <= wait_cnt - WW'(1);
    end
  end
endmodule

// File: tb/tb_mips_mem_arbiter.sv
// tb_mips_mem_arbiter: self-checking bench over three arbiter configurations (default, priority, 3-cycle read latency)
module tb_mips_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst [3];
  logic p0_req [3], p0_we [3], p1_req [3], p1_we [3];
  logic [31:0] p0_addr [3], p0_wdata [3], p1_addr [3], p1_wdata [3];
  logic p0_gnt [3], p0_rvalid [3], p1_gnt [3], p1_rvalid [3];
  logic [31:0] p0_rdata [3], p1_rdata [3];
  logic [31:0] mem_addr [3], mem_wr_data [3], mem_rd_data [3];
  logic mem_wr_ena [3], busy [3], owner [3];
  logic [31:0] mem [3][128];
  logic [31:0] pipe [3][3];
  logic [31:0] shadow [3][64];
  int tests = 0;
  int fails = 0;
  for (genvar g = 0; g < 3; g++) begin : g_dut
    mips_mem_arbiter #(
      .N(32),
      .RD_LATENCY(g == 2 ? 3 : 1),
      .PRIORITY_MODE(g == 1 ? 1 : 0),
      .STARVE_LIMIT(g == 1 ? 3 : 4)
    ) dut (
      .clk(clk), .rst(rst[g]),
      .p0_req(p0_req[g]), .p0_we(p0_we[g]), .p0_addr(p0_addr[g]), .p0_wdata(p0_wdata[g]),
      .p0_gnt(p0_gnt[g]), .p0_rvalid(p0_rvalid[g]), .p0_rdata(p0_rdata[g]),
      .p1_req(p1_req[g]), .p1_we(p1_we[g]), .p1_addr(p1_addr[g]), .p1_wdata(p1_wdata[g]),
      .p1_gnt(p1_gnt[g]), .p1_rvalid(p1_rvalid[g]), .p1_rdata(p1_rdata[g]),
      .mem_addr(mem_addr[g]), .mem_wr_data(mem_wr_data[g]), .mem_wr_ena(mem_wr_ena[g]),
      .mem_rd_data(mem_rd_data[g]), .busy(busy[g]), .owner(owner[g])
    );
    assign mem_rd_data[g] = pipe[g][g == 2 ? 2 : 0];
  end
  function automatic logic [6:0] idx(logic [31:0] a);
    return a[8:2] ^ a[22:16];
  endfunction
  function automatic int lat(int g);
    return g == 2 ? 3 : 1;
  endfunction
  always @(posedge clk) begin
    for (int g = 0; g < 3; g++) begin
      if (mem_wr_ena[g]) mem[g][idx(mem_addr[g])] <= mem_wr_data[g];
      pipe[g][0] <= mem[g][idx(mem_addr[g])];
      pipe[g][1] <= pipe[g][0];
      pipe[g][2] <= pipe[g][1];
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  function automatic logic gnt_of(int g, int p);
    return p != 0 ? p1_gnt[g] : p0_gnt[g];
  endfunction
  function automatic logic rv_of(int g, int p);
    return p != 0 ? p1_rvalid[g] : p0_rvalid[g];
  endfunction
  function automatic logic [31:0] rdata_of(int g, int p);
    return p != 0 ? p1_rdata[g] : p0_rdata[g];
  endfunction
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(int g, int p, logic r, logic we, logic [31:0] a, logic [31:0] d);
    if (p == 0) begin
      p0_req[g] = r; p0_we[g] = we; p0_addr[g] = a; p0_wdata[g] = d;
    end else begin
      p1_req[g] = r; p1_we[g] = we; p1_addr[g] = a; p1_wdata[g] = d;
    end
  endtask
  task automatic rst_pulse(int g);
    drive(g, 0, 0, 0, 0, 0);
    drive(g, 1, 0, 0, 0, 0);
    rst[g] = 1'b0;
    tick();
    rst[g] = 1'b1;
  endtask
  // One isolated transaction from an idle arbiter, checking every cycle of its timeline.
  task automatic do_txn(int g, int p, logic we, logic [31:0] a, logic [31:0] d, logic [31:0] exp);
    drive(g, p, 1, we, a, d);
    @(negedge clk);
    chk("txn_gnt", gnt_of(g, p), 1);
    chk("txn_other_gnt", gnt_of(g, 1 - p), 0);
    tick();
    drive(g, p, 0, we, a, d);
    @(negedge clk);
    chk("txn_mem_addr", mem_addr[g], a);
    chk("txn_wr_ena", mem_wr_ena[g], we);
    chk("txn_busy", busy[g], 1);
    if (we) chk("txn_wr_data", mem_wr_data[g], d);
    if (!we) begin
      for (int i = 1; i < lat(g); i++) begin
        tick();
        @(negedge clk);
        chk("txn_early_rvalid", rv_of(g, p), 0);
      end
      tick();
      @(negedge clk);
      chk("txn_rvalid", rv_of(g, p), 1);
      chk("txn_other_rvalid", rv_of(g, 1 - p), 0);
      chk("txn_rdata", rdata_of(g, p), exp);
    end
    tick();
  endtask
  // Both ports request continuously; the grant sequence must follow pattern(n).
  task automatic both_continuous(int g, int ngr, int period, int ones_at);
    int n = 0;
    rst_pulse(g);
    drive(g, 0, 1, 0, 32'h20000080, 0);
    drive(g, 1, 1, 0, 32'h20000084, 0);
    for (int c = 0; c < 80 && n < ngr; c++) begin
      @(negedge clk);
      if (p0_gnt[g] && p1_gnt[g]) chk("dual_gnt", 1, 0);
      if (p0_gnt[g] || p1_gnt[g]) begin
        chk("grant_order", p1_gnt[g], (n % period) == ones_at);
        n++;
      end
      tick();
    end
    chk("grant_count", n, ngr);
    drive(g, 0, 0, 0, 0, 0);
    drive(g, 1, 0, 0, 0, 0);
    repeat (6) tick();
  endtask
  // Random traffic against a timeline model: a grant at cycle c occupies the port until
  // c+2 (write) or c+2+L (read); a read answers at c+1+L, a write strobes at c+1.
  task automatic run_random(int g, int cycles);
    int busy_until = 0, resp_cycle = -1, wr_cycle = -1, resp_port = 0, sc = 0, w;
    int lim = g == 1 ? 3 : 4;
    logic last = 1'b1;
    logic r [2], we [2], gp [2], eg [2];
    int k [2];
    logic [31:0] wd [2], resp_data = 0, wr_addr = 0, wr_data = 0;
    for (int p = 0; p < 2; p++) begin
      r[p] = 0; we[p] = 0; gp[p] = 0; k[p] = 32; wd[p] = 0;
    end
    rst_pulse(g);
    for (int c = 0; c < cycles; c++) begin
      for (int p = 0; p < 2; p++) begin
        if (r[p] && gp[p]) r[p] = 1'($urandom % 2);
        else if (r[p]) begin
          if ($urandom % 8 == 0) r[p] = 0;
        end else if ($urandom % 2 == 1) begin
          r[p] = 1; we[p] = 1'($urandom % 2); k[p] = 32 + $urandom % 32; wd[p] = $urandom;
        end
        drive(g, p, r[p], we[p], 32'h20000000 + 32'(k[p] * 4), wd[p]);
      end
      eg[0] = 0; eg[1] = 0;
      chk_busy_pre: begin end
      @(negedge clk);
      chk("rnd_busy", busy[g], c < busy_until);
      if (c >= busy_until) begin
        if (r[0] || r[1]) begin
          if (r[0] && r[1]) w = (g == 1) ? int'(sc == lim) : int'(!last);
          else w = r[1] ? 1 : 0;
          eg[w] = 1;
          last = w[0];
          if (we[w]) begin
            shadow[g][k[w]] = wd[w];
            wr_cycle = c + 1; wr_addr = 32'h20000000 + 32'(k[w] * 4); wr_data = wd[w];
            busy_until = c + 2;
          end else begin
            resp_cycle = c + 1 + lat(g); resp_port = w; resp_data = shadow[g][k[w]];
            busy_until = c + 2 + lat(g);
          end
          if (g == 1) sc = (r[1] && w == 0) ? sc + 1 : 0;
        end else if (g == 1) sc = 0;
      end
      chk("rnd_p0_gnt", p0_gnt[g], eg[0]);
      chk("rnd_p1_gnt", p1_gnt[g], eg[1]);
      chk("rnd_wr_ena", mem_wr_ena[g], c == wr_cycle);
      chk("rnd_p0_rvalid", p0_rvalid[g], c == resp_cycle && resp_port == 0);
      chk("rnd_p1_rvalid", p1_rvalid[g], c == resp_cycle && resp_port == 1);
      if (c == resp_cycle) chk("rnd_rdata", rdata_of(g, resp_port), resp_data);
      if (c == wr_cycle) begin
        chk("rnd_wr_addr", mem_addr[g], wr_addr);
        chk("rnd_wr_data", mem_wr_data[g], wr_data);
      end
      gp[0] = eg[0]; gp[1] = eg[1];
      tick();
    end
    drive(g, 0, 0, 0, 0, 0);
    drive(g, 1, 0, 0, 0, 0);
    repeat (6) tick();
  endtask
  typedef struct {
    int port;
    logic we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [6];
  initial begin
    tbl[0] = '{0, 1'b0, 32'h00400000, 32'h0,        32'h2008000A};
    tbl[1] = '{1, 1'b1, 32'h10010000, 32'hDEADBEEF, 32'h0};
    tbl[2] = '{0, 1'b0, 32'h10010000, 32'h0,        32'hDEADBEEF};
    tbl[3] = '{1, 1'b0, 32'h00400000, 32'h0,        32'h2008000A};
    tbl[4] = '{0, 1'b1, 32'h00400000, 32'h12345678, 32'h0};
    tbl[5] = '{1, 1'b0, 32'h00400000, 32'h0,        32'h12345678};
    for (int g = 0; g < 3; g++) begin
      for (int i = 0; i < 128; i++) mem[g][i] = 32'hC0DE0000 | i;
      for (int i = 0; i < 64; i++) shadow[g][i] = 32'hC0DE0000 | i;
      mem[g][idx(32'h00400000)] = 32'h2008000A;
      rst[g] = 1'b0;
      drive(g, 0, 0, 0, 0, 0);
      drive(g, 1, 0, 0, 0, 0);
    end
    drive(0, 0, 1, 0, 32'h00400000, 0);
    @(negedge clk);
    chk("rst_p0_gnt", p0_gnt[0], 0);
    chk("rst_wr_ena", mem_wr_ena[0], 0);
    chk("rst_p0_rvalid", p0_rvalid[0], 0);
    @(negedge clk);
    chk("rst_p0_gnt2", p0_gnt[0], 0);
    chk("rst_p1_gnt", p1_gnt[0], 0);
    chk("rst_mem_addr", mem_addr[0], 0);
    chk("rst_busy", busy[0], 0);
    chk("rst_owner", owner[0], 0);
    tick();
    for (int g = 0; g < 3; g++) rst[g] = 1'b1;
    @(negedge clk);
    chk("post_rst_p0_gnt", p0_gnt[0], 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) tick();
    for (int i = 0; i < 6; i++) do_txn(0, tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp);
    drive(0, 0, 1, 1, 32'h10010000, 32'h0BADF00D);
    @(negedge clk);
    chk("rstw_gnt", p0_gnt[0], 1);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    rst[0] = 1'b0;
    @(negedge clk);
    chk("rstw_wr_ena", mem_wr_ena[0], 0);
    tick();
    rst[0] = 1'b1;
    @(negedge clk);
    chk("rstw_busy", busy[0], 0);
    tick();
    do_txn(0, 1, 0, 32'h10010000, 0, 32'hDEADBEEF);
    both_continuous(0, 6, 2, 1);
    both_continuous(1, 8, 4, 3);
    drive(2, 0, 1, 0, 32'h00400000, 0);
    @(negedge clk);
    chk("wait_rst_gnt", p0_gnt[2], 1);
    tick();
    drive(2, 0, 0, 0, 0, 0);
    tick();
    rst[2] = 1'b0;
    @(negedge clk);
    chk("wait_rst_busy_pre", busy[2], 1);
    chk("wait_rst_rvalid", p0_rvalid[2], 0);
    tick();
    rst[2] = 1'b1;
    @(negedge clk);
    chk("wait_rst_busy", busy[2], 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      @(negedge clk);
      chk("wait_rst_no_rvalid", p0_rvalid[2] | p1_rvalid[2], 0);
    end
    tick();
    do_txn(2, 0, 0, 32'h00400000, 0, 32'h2008000A);
    do_txn(2, 1, 1, 32'h10010000, 32'hCAFEF00D, 0);
    do_txn(2, 0, 0, 32'h10010000, 0, 32'hCAFEF00D);
    for (int g = 0; g < 3; g++) run_random(g, 300);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
